// File: rtl/round_sched.sv
// Round-robin scheduler sharing one combinational rounder among N_REQ requesters, two-stage pipeline.
// Optional macro ROUND_SCHED_MODE_OVR_EN adds cfg_ovr/cfg_rmode to override the sampled rounding mode.
module round_sched #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [27*N_REQ-1:0]   req_z,
    input  logic [N_REQ-1:0]      req_sign,
    input  logic [3*N_REQ-1:0]    req_rmode,
    output logic [26:0]           rnd_z_in,
    output logic                  rnd_sign,
    output logic [2:0]            rnd_rmode,
    input  logic                  rnd_carry,
    input  logic [22:0]           rnd_z_out,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [22:0]           rsp_mant,
    output logic                  rsp_carry,
    output logic                  rsp_inv
`ifdef ROUND_SCHED_MODE_OVR_EN
    ,
    input  logic                  cfg_ovr,
    input  logic [2:0]            cfg_rmode
`endif
);

    function automatic logic [N_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (id == IDW'(i));
        end
        return oh;
    endfunction

    function automatic logic mode_invalid(input logic [2:0] m);
        return m[2] & (m[1] | m[0]);
    endfunction

    logic              r_v1;
    logic [IDW-1:0]    r_id1;
    logic [26:0]       r_z1;
    logic              r_sign1;
    logic [2:0]        r_rmode1;
    logic [IDW-1:0]    r_ptr;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [22:0]       r_rsp_mant;
    logic              r_rsp_carry;
    logic              r_rsp_inv;

    logic              w_rsp_fire;
    logic              w_s2_load;
    logic              w_s1_free;
    logic              w_found;
    logic              w_hit;
    logic [IDW:0]      w_cand;
    logic [IDW-1:0]    w_gnt_id;
    logic              w_accept;
    logic [IDW-1:0]    w_next_ptr;
    logic [2:0]        w_sel_rmode;

    // The stage-2 valid is kept as the one-hot response vector itself, so ownership needs no decode.
    assign w_rsp_fire = |(r_rsp_valid & rsp_ready);
    assign w_s2_load  = r_v1 & (~(|r_rsp_valid) | w_rsp_fire);
    assign w_s1_free  = ~r_v1 | w_s2_load;

    // Round-robin search starting at r_ptr, wrapping past N_REQ-1.
    always_comb begin
        w_found  = 1'b0;
        w_hit    = 1'b0;
        w_cand   = '0;
        w_gnt_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand   = {1'b0, r_ptr} + (IDW+1)'(k);
            w_cand   = (w_cand >= (IDW+1)'(N_REQ)) ? (w_cand - (IDW+1)'(N_REQ)) : w_cand;
            w_hit    = req_valid[w_cand[IDW-1:0]] & ~w_found;
            w_gnt_id = w_hit ? w_cand[IDW-1:0] : w_gnt_id;
            w_found  = w_found | w_hit;
        end
    end

    assign w_accept   = w_s1_free & w_found;
    assign req_ready  = w_accept ? id_onehot(w_gnt_id) : '0;
    assign w_next_ptr = (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : (w_gnt_id + IDW'(1));

`ifdef ROUND_SCHED_MODE_OVR_EN
    assign w_sel_rmode = cfg_ovr ? cfg_rmode : req_rmode[3*int'(w_gnt_id) +: 3];
`else
    assign w_sel_rmode = req_rmode[3*int'(w_gnt_id) +: 3];
`endif

    // Stage 1: operand register feeding the shared rounder, plus the arbitration pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_id1    <= '0;
            r_z1     <= 27'd0;
            r_sign1  <= 1'b0;
            r_rmode1 <= 3'd0;
            r_ptr    <= '0;
        end else if (w_accept) begin
            r_v1     <= 1'b1;
            r_id1    <= w_gnt_id;
            r_z1     <= req_z[27*int'(w_gnt_id) +: 27];
            r_sign1  <= req_sign[w_gnt_id];
            r_rmode1 <= w_sel_rmode;
            r_ptr    <= w_next_ptr;
        end else if (w_s1_free) begin
            r_v1     <= 1'b0;
        end
    end

    // Stage 2: capture the rounder result; a fire and a load in the same cycle keep it valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_mant  <= 23'd0;
            r_rsp_carry <= 1'b0;
            r_rsp_inv   <= 1'b0;
        end else if (w_s2_load) begin
            r_rsp_valid <= id_onehot(r_id1);
            r_rsp_mant  <= rnd_z_out;
            r_rsp_carry <= rnd_carry;
            r_rsp_inv   <= mode_invalid(r_rmode1);
        end else if (w_rsp_fire) begin
            r_rsp_valid <= '0;
        end
    end

    assign rnd_z_in  = r_z1;
    assign rnd_sign  = r_sign1;
    assign rnd_rmode = r_rmode1;
    assign rsp_valid = r_rsp_valid;
    assign rsp_mant  = r_rsp_mant;
    assign rsp_carry = r_rsp_carry;
    assign rsp_inv   = r_rsp_inv;

endmodule

// File: tb/tb_round_sched.sv
// Bench for round_sched: stand-in rounder, slot-level reference model, directed and random stimulus.
module tb_round_sched;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [27*N-1:0]  req_z;
    logic [N-1:0]     req_sign;
    logic [3*N-1:0]   req_rmode;
    logic [26:0]      rnd_z_in;
    logic             rnd_sign;
    logic [2:0]       rnd_rmode;
    logic             rnd_carry;
    logic [22:0]      rnd_z_out;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [22:0]      rsp_mant;
    logic             rsp_carry;
    logic             rsp_inv;
`ifdef ROUND_SCHED_MODE_OVR_EN
    logic             cfg_ovr = 1'b0;
    logic [2:0]       cfg_rmode = 3'd0;
`endif

    always #5 clk = ~clk;

    // Rounder behaviour: mantissa [26:3] with G/R/S; modes RNE, RTZ, RUP, RDN, RMM, others truncate.
    function automatic logic [23:0] round_fn(input logic [26:0] z, input logic s, input logic [2:0] m);
        logic [23:0] man;
        logic        g, r, st, inc;
        logic [24:0] sum;
        man = z[26:3]; g = z[2]; r = z[1]; st = z[0];
        case (m)
            3'b000:  inc = g & (r | st | man[0]);
            3'b010:  inc = ~s & (g | r | st);
            3'b011:  inc = s & (g | r | st);
            3'b100:  inc = g;
            default: inc = 1'b0;
        endcase
        sum = {1'b0, man} + 25'(inc);
        return {sum[24], sum[22:0]};
    endfunction

    assign {rnd_carry, rnd_z_out} = round_fn(rnd_z_in, rnd_sign, rnd_rmode);

    round_sched #(.N_REQ(N), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_z(req_z),
        .req_sign(req_sign), .req_rmode(req_rmode),
        .rnd_z_in(rnd_z_in), .rnd_sign(rnd_sign), .rnd_rmode(rnd_rmode),
        .rnd_carry(rnd_carry), .rnd_z_out(rnd_z_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_mant(rsp_mant), .rsp_carry(rsp_carry), .rsp_inv(rsp_inv)
`ifdef ROUND_SCHED_MODE_OVR_EN
        , .cfg_ovr(cfg_ovr), .cfg_rmode(cfg_rmode)
`endif
    );

    typedef struct {
        bit          v;
        int          id;
        logic [26:0] z;
        logic        sign;
        logic [2:0]  rm;
        logic [22:0] mant;
        logic        carry;
        logic        inv;
    } slot_t;

    slot_t        m_s1, m_s2;
    int           m_ptr;
    int           n_cmp = 0, n_mis = 0;
    int           n_acc = 0, dut_fires = 0;
    int           acc_id;
    bit           hold_all = 1'b0;
    logic [N-1:0] pend_v = '0;
    logic [26:0]  pz [N];
    logic         ps [N];
    logic [2:0]   pm [N];
    logic [N-1:0] rdy_drv = '1;
    logic [N-1:0] obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic new_data(input int i);
        pz[i] = 27'($urandom);
        if ($urandom_range(0, 3) == 0) pz[i][26:3] = '1;
        ps[i] = 1'($urandom);
        pm[i] = 3'($urandom_range(0, 7));
    endtask

    // One clock cycle: drive, predict and compare, advance the model, then cross the edge.
    task automatic step();
        bit           fire, s2load, free, found;
        int           g;
        logic [N-1:0] exp_rdy, exp_rv;
        slot_t        ns;
        logic [23:0]  res;
        for (int i = 0; i < N; i++) begin
            req_z[27*i +: 27]   = pz[i];
            req_sign[i]         = ps[i];
            req_rmode[3*i +: 3] = pm[i];
        end
        req_valid = pend_v;
        rsp_ready = rdy_drv;
        #2;
        fire   = m_s2.v && rdy_drv[m_s2.id];
        s2load = m_s1.v && (!m_s2.v || fire);
        free   = !m_s1.v || s2load;
        found  = 1'b0;
        g      = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (free && !found && pend_v[c]) begin
                found = 1'b1;
                g = c;
            end
        end
        exp_rdy = found ? (N'(1) << g) : '0;
        obs_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_rv = m_s2.v ? (N'(1) << m_s2.id) : '0;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (m_s2.v) begin
            chk("rsp_mant", 32'(rsp_mant), 32'(m_s2.mant));
            chk("rsp_carry", 32'(rsp_carry), 32'(m_s2.carry));
            chk("rsp_inv", 32'(rsp_inv), 32'(m_s2.inv));
        end
        if (m_s1.v) begin
            chk("rnd_z_in", 32'(rnd_z_in), 32'(m_s1.z));
            chk("rnd_sign_mode", 32'({rnd_sign, rnd_rmode}), 32'({m_s1.sign, m_s1.rm}));
        end
        if (|(rsp_valid & rsp_ready)) dut_fires++;
        if (s2load) m_s2 = m_s1;
        else if (fire) m_s2.v = 1'b0;
        if (found) begin
            ns.v = 1'b1; ns.id = g; ns.z = pz[g]; ns.sign = ps[g]; ns.rm = pm[g];
`ifdef ROUND_SCHED_MODE_OVR_EN
            if (cfg_ovr) ns.rm = cfg_rmode;
`endif
            res = round_fn(ns.z, ns.sign, ns.rm);
            ns.carry = res[23];
            ns.mant  = res[22:0];
            ns.inv   = (ns.rm >= 3'd5);
            m_s1  = ns;
            m_ptr = (g + 1) % N;
            n_acc++;
            acc_id = g;
            if (hold_all) new_data(g);
            else pend_v[g] = 1'b0;
        end else begin
            acc_id = -1;
            if (free) m_s1.v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rnd_z_in", 32'(rnd_z_in), 32'd0);
        chk("rst_rsp_mant", 32'({rsp_inv, rsp_carry, rsp_mant}), 32'd0);
        n_acc = n_acc - int'(m_s1.v) - int'(m_s2.v);
        m_s1.v = 1'b0;
        m_s2.v = 1'b0;
        m_ptr  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int          exp_g [5] = '{0, 1, 2, 3, 0};
    logic [2:0]  t4_rm [3] = '{3'b000, 3'b100, 3'b111};
    logic [22:0] t4_mant [3] = '{23'd0, 23'd1, 23'd0};
    logic        t4_inv [3] = '{1'b0, 1'b0, 1'b1};
    logic [22:0] mant0;

    initial begin
        m_s1.v = 1'b0;
        m_s2.v = 1'b0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) begin
            pz[i] = 27'd0; ps[i] = 1'b0; pm[i] = 3'd0;
        end
        req_valid = '0; req_z = '0; req_sign = '0; req_rmode = '0; rsp_ready = '1;
        do_reset();
        chk("reset_ready", 32'(req_ready), 32'd0);

        // Single request from requester 2, overflow on rounding.
        pend_v[2] = 1'b1; pz[2] = 27'h7FFFFFC; ps[2] = 1'b0; pm[2] = 3'b100;
        step();
        chk("t1_ready", 32'(obs_rdy), 32'h4);
        chk("t1_lat", 32'(rsp_valid), 32'h0);
        step();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t1_resp", 32'({rsp_inv, rsp_carry, rsp_mant}), 32'h0080_0000);
        step();

        // All requesters held valid: strict rotation.
        do_reset();
        hold_all = 1'b1;
        for (int i = 0; i < N; i++) new_data(i);
        pend_v = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_grant", 32'(acc_id), 32'(exp_g[k]));
            if (k >= 1) chk("t2_rsp", 32'(rsp_valid), 32'(N'(1) << (k - 1)));
        end
        hold_all = 1'b0;
        pend_v = '0;
        repeat (3) step();

        // Backpressure on requester 0's response.
        do_reset();
        rdy_drv = 4'b1110;
        pend_v[0] = 1'b1; new_data(0);
        step();
        pend_v[1] = 1'b1; new_data(1);
        step();
        chk("t3_acc1", 32'(acc_id), 32'd1);
        pend_v[2] = 1'b1; new_data(2);
        mant0 = rsp_mant;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_ready", 32'(obs_rdy), 32'd0);
            chk("t3_hold", 32'(rsp_mant), 32'(mant0));
            chk("t3_hold_valid", 32'(rsp_valid), 32'h1);
        end
        rdy_drv = '1;
        step();
        chk("t3_next", 32'(rsp_valid), 32'h2);
        repeat (3) step();

        // Tie-rounding cases on a half-way operand.
        for (int k = 0; k < 3; k++) begin
            pend_v[0] = 1'b1; pz[0] = 27'h0000004; ps[0] = 1'b0; pm[0] = t4_rm[k];
            step();
            step();
            chk("t4_mant", 32'(rsp_mant), 32'(t4_mant[k]));
            chk("t4_inv", 32'(rsp_inv), 32'(t4_inv[k]));
        end
        step();

        // Reset while both stages are full.
        rdy_drv = '0;
        hold_all = 1'b1;
        pend_v = '1;
        repeat (3) step();
        hold_all = 1'b0;
        #2;
        do_reset();
        rdy_drv = '1;
        chk("t5_no_stale", 32'(rsp_valid), 32'd0);
        pend_v = '1;
        step();
        chk("t5_grant0", 32'(acc_id), 32'd0);
        pend_v = '0;
        repeat (3) step();

`ifdef ROUND_SCHED_MODE_OVR_EN
        // Mode override replaces the requester's rounding mode.
        cfg_ovr = 1'b1; cfg_rmode = 3'b100;
        pend_v[1] = 1'b1; pz[1] = 27'h0000004; ps[1] = 1'b0; pm[1] = 3'b000;
        step(); step();
        chk("t6_ovr", 32'(rsp_mant), 32'd1);
        cfg_ovr = 1'b0;
        pend_v[1] = 1'b1;
        step(); step();
        chk("t6_noovr", 32'(rsp_mant), 32'd0);
        step();
`endif

        // Random traffic with random response backpressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
                    new_data(i);
                    pend_v[i] = 1'b1;
                end
            end
            rdy_drv = N'($urandom);
`ifdef ROUND_SCHED_MODE_OVR_EN
            if (!(|pend_v)) begin
                cfg_ovr = 1'($urandom);
                cfg_rmode = 3'($urandom);
            end
`endif
            step();
        end
        pend_v = '0;
        rdy_drv = '1;
        repeat (4) step();
        chk("no_loss", 32'(dut_fires), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
